// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
// Status outputs are decoded from registered state only, so they never glitch with the handshakes.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;
  assign in_ready    = ~full;
  assign out_valid   = ~empty;

  // Empty reads as zero rather than whatever stale word sits under rd_ptr.
  assign out_data = empty ? '0 : mem_q[rd_ptr_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; a write coinciding with reset/flush is dropped.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a 16x16 instance and a 5x8 instance checked against queue models.
module tb_sync_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, flush;

  logic [15:0] in_data16, out_data16;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [4:0]  count16;
  logic        full16, empty16, afull16;

  logic [7:0]  in_data5, out_data5;
  logic        in_valid5, in_ready5, out_valid5, out_ready5;
  logic [2:0]  count5;
  logic        full5, empty5, afull5;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q16[$];
  logic [7:0]  q5[$];

  sync_fifo #(.WIDTH(16), .DEPTH(16), .AFULL(12)) dut16 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16),
    .count(count16), .full(full16), .empty(empty16), .almost_full(afull16)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(5), .AFULL(4)) dut5 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .count(count5), .full(full5), .empty(empty5), .almost_full(afull5)
  );

  wire [25:0] act16 = {count16, empty16, full16, afull16, in_ready16, out_valid16, out_data16};
  wire [15:0] act5  = {count5, empty5, full5, afull5, in_ready5, out_valid5, out_data5};

  // Reference: a bounded queue per instance, updated from the pre-edge inputs.
  always @(posedge clock) begin
    bit p, r;
    if (reset || flush) begin
      q16.delete();
      q5.delete();
    end else begin
      p = in_valid16 && (q16.size() < 16);
      r = out_ready16 && (q16.size() > 0);
      if (r) void'(q16.pop_front());
      if (p) q16.push_back(in_data16);
      p = in_valid5 && (q5.size() < 5);
      r = out_ready5 && (q5.size() > 0);
      if (r) void'(q5.pop_front());
      if (p) q5.push_back(in_data5);
    end
  end

  function automatic logic [25:0] exp16();
    int n = q16.size();
    return {5'(n), n == 0, n == 16, n >= 12, n != 16, n != 0, (n == 0) ? 16'h0 : q16[0]};
  endfunction

  function automatic logic [15:0] exp5();
    int n = q5.size();
    return {3'(n), n == 0, n == 5, n >= 4, n != 5, n != 0, (n == 0) ? 8'h0 : q5[0]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    in_valid16 = 1'b1; in_data16 = 16'hdead; out_ready16 = 1'b1;
    in_valid5  = 1'b1; in_data5  = 8'had;    out_ready5  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0;
    in_valid5  = 1'b0; out_ready5  = 1'b0;
    checks++;
    if (act16 !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      failures++; $display("FAIL reset_state16 got=%h exp=%h", act16, {5'd0, 5'b10010, 16'h0});
    end
    checks++;
    if (act5 !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0}) begin
      failures++; $display("FAIL reset_state5 got=%h exp=%h", act5, {3'd0, 5'b10010, 8'h0});
    end
  endtask

  task automatic test_fill();
    in_valid16 = 1'b1; out_ready16 = 1'b0;
    in_valid5  = 1'b1; out_ready5  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data16 = 16'(i + 1);
      in_data5  = 8'(i + 1);
      @(posedge clock); #1;
      checks++;
      if (act16 !== exp16()) begin
        failures++; $display("FAIL fill16[%0d] got=%h exp=%h", i, act16, exp16());
      end
      checks++;
      if (afull16 !== (i + 1 >= 12) || count16 !== 5'(i + 1)) begin
        failures++; $display("FAIL fill_afull16[%0d] got af=%b cnt=%0d exp af=%b cnt=%0d",
                             i, afull16, count16, (i + 1 >= 12), i + 1);
      end
      checks++;
      if (act5 !== exp5()) begin
        failures++; $display("FAIL fill5[%0d] got=%h exp=%h", i, act5, exp5());
      end
    end
    checks++;
    if (full16 !== 1'b1 || in_ready16 !== 1'b0) begin
      failures++; $display("FAIL full16 got full=%b in_ready=%b exp full=1 in_ready=0", full16, in_ready16);
    end
    in_data16 = 16'hBEEF;
    in_data5  = 8'hEF;
    @(posedge clock); #1;
    in_valid16 = 1'b0; in_valid5 = 1'b0;
    checks++;
    if (count16 !== 5'd16 || out_data16 !== 16'h0001) begin
      failures++; $display("FAIL overflow16 got cnt=%0d head=%h exp cnt=16 head=0001", count16, out_data16);
    end
    checks++;
    if (act5 !== {3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01}) begin
      failures++; $display("FAIL overflow5 got=%h exp=%h", act5, {3'd5, 5'b01101, 8'h01});
    end
  endtask

  task automatic test_drain();
    out_ready16 = 1'b1; out_ready5 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_data16 !== 16'(i + 1) || out_valid16 !== 1'b1) begin
        failures++; $display("FAIL drain16[%0d] got=%h v=%b exp=%h v=1", i, out_data16, out_valid16, 16'(i + 1));
      end
      checks++;
      if (act5 !== exp5()) begin
        failures++; $display("FAIL drain5[%0d] got=%h exp=%h", i, act5, exp5());
      end
      @(posedge clock); #1;
    end
    out_ready16 = 1'b0; out_ready5 = 1'b0;
    checks++;
    if (empty16 !== 1'b1 || count16 !== 5'd0 || out_data16 !== 16'h0) begin
      failures++; $display("FAIL drained16 got empty=%b cnt=%0d data=%h exp 1 0 0000", empty16, count16, out_data16);
    end
    checks++;
    if (empty5 !== 1'b1 || count5 !== 3'd0) begin
      failures++; $display("FAIL drained5 got empty=%b cnt=%0d exp 1 0", empty5, count5);
    end
  endtask

  task automatic test_stream();
    in_valid16 = 1'b1; out_ready16 = 1'b0; out_ready5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data16 = 16'($urandom);
      in_data5  = 8'($urandom);
      in_valid5 = (i < 3);
      @(posedge clock); #1;
    end
    out_ready16 = 1'b1; in_valid5 = 1'b1; out_ready5 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (act16 !== exp16()) begin
        failures++; $display("FAIL stream16[%0d] got=%h exp=%h", i, act16, exp16());
      end
      in_data16 = 16'($urandom);
      in_data5  = 8'($urandom);
      @(posedge clock); #1;
      checks++;
      if (count16 !== 5'd5) begin
        failures++; $display("FAIL stream_count16[%0d] got=%0d exp=5", i, count16);
      end
      checks++;
      if (act5 !== exp5() || count5 !== 3'd3) begin
        failures++; $display("FAIL stream5[%0d] got=%h exp=%h", i, act5, exp5());
      end
    end
    in_valid16 = 1'b0; in_valid5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      checks++;
      if (act16 !== exp16() || act5 !== exp5()) begin
        failures++; $display("FAIL stream_tail[%0d] got=%h/%h exp=%h/%h", i, act16, act5, exp16(), exp5());
      end
    end
    out_ready16 = 1'b0; out_ready5 = 1'b0;
  endtask

  task automatic test_fwft();
    in_data16 = 16'h1234; in_valid16 = 1'b1; out_ready16 = 1'b1;
    checks++;
    if (out_valid16 !== 1'b0 || out_data16 !== 16'h0) begin
      failures++; $display("FAIL fwft_pre got v=%b data=%h exp v=0 data=0000", out_valid16, out_data16);
    end
    @(posedge clock); #1;
    in_valid16 = 1'b0;
    checks++;
    if (out_valid16 !== 1'b1 || out_data16 !== 16'h1234 || count16 !== 5'd1) begin
      failures++; $display("FAIL fwft_head got v=%b data=%h cnt=%0d exp 1 1234 1", out_valid16, out_data16, count16);
    end
    @(posedge clock); #1;
    out_ready16 = 1'b0;
    checks++;
    if (empty16 !== 1'b1 || out_valid16 !== 1'b0 || out_data16 !== 16'h0) begin
      failures++; $display("FAIL fwft_pop got empty=%b v=%b data=%h exp 1 0 0000", empty16, out_valid16, out_data16);
    end
  endtask

  task automatic test_flush();
    logic [15:0] words [4];
    in_valid16 = 1'b1; out_ready16 = 1'b0; out_ready5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_data16 = 16'($urandom);
      in_data5  = 8'($urandom);
      in_valid5 = (i < 4);
      @(posedge clock); #1;
    end
    checks++;
    if (count16 !== 5'd7 || act16 !== exp16()) begin
      failures++; $display("FAIL preflush16 got=%h exp=%h", act16, exp16());
    end
    flush = 1'b1; in_data16 = 16'hffff; in_data5 = 8'hff; in_valid5 = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++;
    if (act16 !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      failures++; $display("FAIL flush16 got=%h exp=%h", act16, {5'd0, 5'b10010, 16'h0});
    end
    checks++;
    if (act5 !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0}) begin
      failures++; $display("FAIL flush5 got=%h exp=%h", act5, {3'd0, 5'b10010, 8'h0});
    end
    for (int i = 0; i < 3; i++) begin
      in_data16 = 16'($urandom);
      @(posedge clock); #1;
    end
    reset = 1'b1; in_data16 = 16'hffff; out_ready16 = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; out_ready16 = 1'b0;
    checks++;
    if (act16 !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      failures++; $display("FAIL midreset16 got=%h exp=%h", act16, {5'd0, 5'b10010, 16'h0});
    end
    for (int i = 0; i < 4; i++) begin
      words[i]  = 16'($urandom);
      in_data16 = words[i];
      @(posedge clock); #1;
    end
    in_valid16 = 1'b0; in_valid5 = 1'b0; out_ready16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data16 !== words[i]) begin
        failures++; $display("FAIL post_reset_order[%0d] got=%h exp=%h", i, out_data16, words[i]);
      end
      @(posedge clock); #1;
    end
    out_ready16 = 1'b0;
    checks++;
    if (empty16 !== 1'b1) begin
      failures++; $display("FAIL post_reset_empty got=%b exp=1", empty16);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid16  = ($urandom_range(0, 3) != 0);
      out_ready16 = ($urandom_range(0, 2) == 0) ^ (i >= 200);
      in_valid5   = ($urandom_range(0, 1) != 0);
      out_ready5  = ($urandom_range(0, 1) != 0);
      in_data16   = 16'($urandom);
      in_data5    = 8'($urandom);
      flush       = ($urandom_range(0, 59) == 0);
      @(posedge clock); #1;
      checks++;
      if (act16 !== exp16()) begin
        failures++; $display("FAIL random16[%0d] got=%h exp=%h", i, act16, exp16());
      end
      checks++;
      if (act5 !== exp5()) begin
        failures++; $display("FAIL random5[%0d] got=%h exp=%h", i, act5, exp5());
      end
    end
    flush = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_data16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    in_data5  = '0; in_valid5  = 1'b0; out_ready5  = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_fwft();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
